// File: rtl/register_file_sb.sv
// Two-read/one-write register file with optional hardwired-zero r0, write-to-read
// bypass, and a per-register load-pending scoreboard with a registered count.
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] writeSel,
    input  logic [XLEN-1:0]   writeData,
    input  logic [ADDR_W-1:0] readSel1,
    output logic [XLEN-1:0]   readData1,
    input  logic [ADDR_W-1:0] readSel2,
    output logic [XLEN-1:0]   readData2,
    input  logic              pendSetEn,
    input  logic [ADDR_W-1:0] pendSetSel,
    output logic              hazard,
    output logic [ADDR_W:0]   pendingCount
);

    logic [XLEN-1:0]  regFile_r [NREGS];
    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] pendingNext_s;
    logic [ADDR_W:0]  pendingCount_r;
    logic [ADDR_W:0]  countNext_s;

    logic wr_s;
    logic ps_s;
    logic inc_s;
    logic dec_s;
    logic zero1_s;
    logic zero2_s;
    logic byp1_s;
    logic byp2_s;

    assign wr_s    = writeEn   && !(ZERO_REG && (writeSel   == {ADDR_W{1'b0}}));
    assign ps_s    = pendSetEn && !(ZERO_REG && (pendSetSel == {ADDR_W{1'b0}}));
    assign zero1_s = ZERO_REG && (readSel1 == {ADDR_W{1'b0}});
    assign zero2_s = ZERO_REG && (readSel2 == {ADDR_W{1'b0}});
    assign byp1_s  = BYPASS && wr_s && (writeSel == readSel1);
    assign byp2_s  = BYPASS && wr_s && (writeSel == readSel2);

    assign readData1 = zero1_s ? {XLEN{1'b0}} : (byp1_s ? writeData : regFile_r[readSel1]);
    assign readData2 = zero2_s ? {XLEN{1'b0}} : (byp2_s ? writeData : regFile_r[readSel2]);

    // A register whose data is being bypassed this cycle is no longer a hazard
    assign hazard = (pending_r[readSel1] && !zero1_s && !byp1_s) ||
                    (pending_r[readSel2] && !zero2_s && !byp2_s);

    // Register array storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_s) begin
            regFile_r[writeSel] <= writeData;
        end
    end

    // Next pending vector: a set on the same register as a retiring write wins
    always_comb begin
        pendingNext_s = pending_r;
        for (int i = 0; i < NREGS; i++) begin
            if (ps_s && (pendSetSel == ADDR_W'(i))) begin
                pendingNext_s[i] = 1'b1;
            end else if (wr_s && (writeSel == ADDR_W'(i))) begin
                pendingNext_s[i] = 1'b0;
            end else begin
                pendingNext_s[i] = pending_r[i];
            end
        end
    end

    assign inc_s = ps_s && !pending_r[pendSetSel];
    assign dec_s = wr_s && pending_r[writeSel] && !(ps_s && (pendSetSel == writeSel));
    assign countNext_s = pendingCount_r + {{ADDR_W{1'b0}}, inc_s} - {{ADDR_W{1'b0}}, dec_s};

    // Scoreboard state and its incrementally maintained popcount
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r      <= {NREGS{1'b0}};
            pendingCount_r <= {(ADDR_W+1){1'b0}};
        end else begin
            pending_r      <= pendingNext_s;
            pendingCount_r <= countNext_s;
        end
    end

    assign pendingCount = pendingCount_r;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: one default instance (bypass on) and one with bypass off share stimulus.
module tb_register_file_sb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              writeEn;
    logic [ADDR_W-1:0] writeSel;
    logic [XLEN-1:0]   writeData;
    logic [ADDR_W-1:0] readSel1;
    logic [ADDR_W-1:0] readSel2;
    logic              pendSetEn;
    logic [ADDR_W-1:0] pendSetSel;

    logic [XLEN-1:0] rdA1, rdA2, rdB1, rdB2;
    logic            hzA, hzB;
    logic [ADDR_W:0] cntA, cntB;

    int checks;
    int failures;

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1), .ZERO_REG(1'b1)) dutA (
        .clk(clk), .rst(rst), .writeEn(writeEn), .writeSel(writeSel), .writeData(writeData),
        .readSel1(readSel1), .readData1(rdA1), .readSel2(readSel2), .readData2(rdA2),
        .pendSetEn(pendSetEn), .pendSetSel(pendSetSel), .hazard(hzA), .pendingCount(cntA)
    );

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b0), .ZERO_REG(1'b1)) dutB (
        .clk(clk), .rst(rst), .writeEn(writeEn), .writeSel(writeSel), .writeData(writeData),
        .readSel1(readSel1), .readData1(rdB1), .readSel2(readSel2), .readData2(rdB2),
        .pendSetEn(pendSetEn), .pendSetSel(pendSetSel), .hazard(hzB), .pendingCount(cntB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        writeEn    = 1'b0;
        writeSel   = 5'd0;
        writeData  = 32'd0;
        readSel1   = 5'd5;
        readSel2   = 5'd0;
        pendSetEn  = 1'b0;
        pendSetSel = 5'd0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset_rd1", rdA1, 32'd0);
        check("reset_cnt", 32'(cntA), 32'd0);
        check("reset_hz", 32'(hzA), 32'd0);

        // Mid-cycle asynchronous reset after writing r5 and marking it pending
        writeEn = 1'b1; writeSel = 5'd5; writeData = 32'hDEADBEEF;
        pendSetEn = 1'b1; pendSetSel = 5'd5;
        tick();
        writeEn = 1'b0; pendSetEn = 1'b0;
        #1;
        check("pre_rst_rd1", rdA1, 32'hDEADBEEF);
        check("pre_rst_cnt", 32'(cntA), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_rd1", rdA1, 32'd0);
        check("async_rst_cnt", 32'(cntA), 32'd0);
        check("async_rst_hz", 32'(hzA), 32'd0);
        rst = 1'b0;
        tick();

        // Basic writes and reads on both ports, r0 hardwired
        writeEn = 1'b1; writeSel = 5'd1; writeData = 32'hFFFFFFFF;
        tick();
        writeSel = 5'd2; writeData = 32'h0F0F0F0F;
        tick();
        writeEn = 1'b0; readSel1 = 5'd1; readSel2 = 5'd2;
        #1;
        check("rd_r1", rdA1, 32'hFFFFFFFF);
        check("rd_r2", rdA2, 32'h0F0F0F0F);
        writeEn = 1'b1; writeSel = 5'd0; writeData = 32'h12345678; readSel1 = 5'd0;
        #1;
        check("r0_during_wr", rdA1, 32'd0);
        tick();
        writeEn = 1'b0;
        #1;
        check("r0_after_wr", rdA1, 32'd0);
        check("r0_after_wr_nobyp", rdB1, 32'd0);

        // Bypass versus stored value
        writeEn = 1'b1; writeSel = 5'd3; writeData = 32'h11111111;
        tick();
        writeData = 32'hA5A5A5A5; readSel1 = 5'd3;
        #1;
        check("byp_on", rdA1, 32'hA5A5A5A5);
        check("byp_off_old", rdB1, 32'h11111111);
        tick();
        writeEn = 1'b0;
        #1;
        check("byp_off_new", rdB1, 32'hA5A5A5A5);

        // Scoreboard set, hazard, retire
        pendSetEn = 1'b1; pendSetSel = 5'd7;
        tick();
        pendSetEn = 1'b0; readSel2 = 5'd7;
        #1;
        check("sb_cnt1", 32'(cntA), 32'd1);
        check("sb_hz", 32'(hzA), 32'd1);
        writeEn = 1'b1; writeSel = 5'd7; writeData = 32'h00000077;
        #1;
        check("sb_hz_byp", 32'(hzA), 32'd0);
        check("sb_hz_nobyp", 32'(hzB), 32'd1);
        tick();
        writeEn = 1'b0;
        #1;
        check("sb_cnt_retired", 32'(cntA), 32'd0);
        check("sb_hz_nobyp_after", 32'(hzB), 32'd0);
        pendSetEn = 1'b1; pendSetSel = 5'd0;
        tick();
        pendSetEn = 1'b0;
        #1;
        check("sb_r0_set", 32'(cntA), 32'd0);

        // Simultaneous set and clear
        pendSetEn = 1'b1; pendSetSel = 5'd4;
        tick();
        writeEn = 1'b1; writeSel = 5'd4; writeData = 32'h44444444;
        tick();
        writeEn = 1'b0; pendSetEn = 1'b0; readSel1 = 5'd4; readSel2 = 5'd4;
        #1;
        check("sim_same_cnt", 32'(cntA), 32'd1);
        check("sim_same_hz", 32'(hzA), 32'd1);
        check("sim_same_data", rdA1, 32'h44444444);
        pendSetEn = 1'b1; pendSetSel = 5'd9;
        writeEn = 1'b1; writeSel = 5'd4; writeData = 32'h55555555;
        tick();
        pendSetEn = 1'b0; writeEn = 1'b0;
        #1;
        check("sim_diff_cnt", 32'(cntA), 32'd1);
        check("sim_diff_hz4", 32'(hzA), 32'd0);
        readSel1 = 5'd9;
        #1;
        check("sim_diff_hz9", 32'(hzA), 32'd1);
        writeEn = 1'b1; writeSel = 5'd9; writeData = 32'h99999999;
        tick();
        writeEn = 1'b0;
        #1;
        check("sim_diff_retire", 32'(cntA), 32'd0);

        // Saturation of the scoreboard
        pendSetEn = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            pendSetSel = ADDR_W'(i);
            tick();
        end
        pendSetEn = 1'b0; readSel1 = 5'd31; readSel2 = 5'd0;
        #1;
        check("sat_cnt31", 32'(cntA), 32'd31);
        check("sat_cnt31_b", 32'(cntB), 32'd31);
        check("sat_hz31", 32'(hzA), 32'd1);
        pendSetEn = 1'b1; pendSetSel = 5'd5;
        tick();
        pendSetEn = 1'b0;
        #1;
        check("sat_reset_r5", 32'(cntA), 32'd31);
        writeEn = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            writeSel  = ADDR_W'(i);
            writeData = 32'(i);
            tick();
        end
        writeEn = 1'b0;
        #1;
        check("sat_retire_all", 32'(cntA), 32'd0);
        check("sat_retire_hz", 32'(hzA), 32'd0);
        check("sat_r31_data", rdA1, 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
